pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 118 +++++++++++
 tb/tb_pipe_stage_reg.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register (main + skid) with valid/ready handshake,
// flush, and a saturating back-pressure cycle counter.
module pipe_stage_reg #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned CTRL_W  = 8,
    parameter int unsigned STALL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [CTRL_W-1:0]  in_ctrl,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [1:0]         occupancy,
    output logic [STALL_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   mainData_q, skidData_q;
    logic [CTRL_W-1:0]   mainCtrl_q, skidCtrl_q;
    logic [STALL_W-1:0]  stallCnt_q;

    logic accept, consume, stallEvent;
    logic loadMain, loadSkid, skidToMain;

    // Handshake outputs depend only on registered state.
    assign in_ready   = (state_q != StFull);
    assign out_valid  = (state_q != StEmpty);
    assign out_data   = mainData_q;
    assign out_ctrl   = out_valid ? mainCtrl_q : '0;
    assign stall_cnt  = stallCnt_q;

    assign accept     = in_valid && in_ready;
    assign consume    = out_valid && out_ready;
    assign stallEvent = out_valid && !out_ready;

    always_comb begin
        unique case (state_q)
            StOne:   occupancy = 2'd1;
            StFull:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        loadMain   = 1'b0;
        loadSkid   = 1'b0;
        skidToMain = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    loadMain = 1'b1;
                    state_d  = StOne;
                end
            end
            StOne: begin
                if (accept && consume) begin
                    loadMain = 1'b1;
                end else if (accept) begin
                    loadSkid = 1'b1;
                    state_d  = StFull;
                end else if (consume) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (consume) begin
                    skidToMain = 1'b1;
                    state_d    = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Flush drops everything, including a concurrent accept; payloads are left as-is.
        if (flush) begin
            state_d    = StEmpty;
            loadMain   = 1'b0;
            loadSkid   = 1'b0;
            skidToMain = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StEmpty;
            mainData_q <= '0;
            mainCtrl_q <= '0;
            skidData_q <= '0;
            skidCtrl_q <= '0;
            stallCnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (loadMain) begin
                mainData_q <= in_data;
                mainCtrl_q <= in_ctrl;
            end else if (skidToMain) begin
                mainData_q <= skidData_q;
                mainCtrl_q <= skidCtrl_q;
            end
            if (loadSkid) begin
                skidData_q <= in_data;
                skidCtrl_q <= in_ctrl;
            end
            if (stallEvent && (stallCnt_q != {STALL_W{1'b1}})) begin
                stallCnt_q <= stallCnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_pipe_stage_reg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned CTRL_W    = 8;
    localparam int unsigned STALL_W   = 4;
    localparam int unsigned STALL_MAX = (1 << STALL_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               flush = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data = '0;
    logic [CTRL_W-1:0]  in_ctrl = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [DATA_W-1:0]  out_data;
    logic [CTRL_W-1:0]  out_ctrl;
    logic [1:0]         occupancy;
    logic [STALL_W-1:0] stall_cnt;

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .STALL_W(STALL_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: FIFO of held entries, last head payload, stall count.
    logic [DATA_W+CTRL_W-1:0] modelQ[$];
    logic [DATA_W-1:0]        lastHead = '0;
    int unsigned              modelStall = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic modelStep();
        bit acc, con;
        if (!rst) begin
            modelQ.delete();
            lastHead   = '0;
            modelStall = 0;
            return;
        end
        acc = in_valid && (modelQ.size() < 2);
        con = (modelQ.size() > 0) && out_ready;
        if (modelQ.size() > 0 && !out_ready && modelStall < STALL_MAX) modelStall++;
        if (flush) begin
            modelQ.delete();
        end else begin
            if (con) void'(modelQ.pop_front());
            if (acc) modelQ.push_back({in_ctrl, in_data});
        end
        if (modelQ.size() > 0) lastHead = modelQ[0][DATA_W-1:0];
    endtask

    task automatic compareAll();
        logic [CTRL_W-1:0] expCtrl;
        expCtrl = (modelQ.size() > 0) ? modelQ[0][DATA_W+CTRL_W-1:DATA_W] : '0;
        checkVal("out_valid", 32'(out_valid), 32'(modelQ.size() > 0));
        checkVal("in_ready",  32'(in_ready),  32'(modelQ.size() < 2));
        checkVal("occupancy", 32'(occupancy), 32'(modelQ.size()));
        checkVal("out_data",  32'(out_data),  32'(lastHead));
        checkVal("out_ctrl",  32'(out_ctrl),  32'(expCtrl));
        checkVal("stall_cnt", 32'(stall_cnt), 32'(modelStall));
    endtask

    // Apply inputs, clock one edge, update model, then compare away from the edge.
    task automatic step(input logic r, input logic fl, input logic v,
                        input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                        input logic rdy);
        rst       = r;
        flush     = fl;
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = rdy;
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
    endtask

    initial begin
        // Reset
        step(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h1234, 8'h56, 1'b1);
        checkVal("reset_in_ready", 32'(in_ready), 32'd1);

        // Streaming 0x0001..0x0010
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b0, 1'b1, DATA_W'(i), CTRL_W'(i + 8'h80), 1'b1);
            checkVal("stream_data", 32'(out_data), 32'(i));
        end
        step(1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1);

        // Back-pressure
        step(1'b1, 1'b0, 1'b1, 16'hAAAA, 8'h11, 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'hBBBB, 8'h22, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 16'hCCCC, 8'h33, 1'b0);
            checkVal("bp_head", 32'(out_data), 32'hAAAA);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 16'hCCCC, 8'h33, 1'b1);
        step(1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1);

        // Flush from full with a concurrent offer
        step(1'b1, 1'b0, 1'b1, 16'h1111, 8'h01, 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'h2222, 8'h02, 1'b0);
        step(1'b1, 1'b1, 1'b1, 16'h3333, 8'h03, 1'b0);
        checkVal("flush_valid", 32'(out_valid), 32'd0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1);

        // Stall saturation, unaffected by flush, cleared by reset
        step(1'b1, 1'b0, 1'b1, 16'h5A5A, 8'h44, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
        checkVal("stall_sat", 32'(stall_cnt), 32'd15);
        step(1'b1, 1'b1, 1'b0, 16'h0, 8'h0, 1'b0);
        checkVal("stall_after_flush", 32'(stall_cnt), 32'd15);
        step(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
        checkVal("stall_after_rst", 32'(stall_cnt), 32'd0);

        // Reset mid-operation from FULL
        step(1'b1, 1'b0, 1'b1, 16'h7777, 8'h07, 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'h8888, 8'h08, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h9999, 8'h09, 1'b0);
        checkVal("midrst_data", 32'(out_data), 32'd0);
        step(1'b1, 1'b0, 1'b1, 16'hABCD, 8'h0A, 1'b1);
        checkVal("midrst_first", 32'(out_data), 32'hABCD);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0), DATA_W'($urandom), CTRL_W'($urandom),
                 ($urandom_range(0, 2) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
